// File: rtl/array_divider_seq.sv
//==============================================================================
// Module      : array_divider_seq
// Description : Sequential restoring divider. Divides a 2*WIDTH-bit unsigned
//               dividend by a WIDTH-bit unsigned divisor, producing one
//               quotient bit per cycle (MSB first) behind valid/ready
//               handshakes on both the input and the result side.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module array_divider_seq #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               div_by_zero,
  output logic               busy
);

  localparam int QW = 2 * WIDTH;
  localparam int CW = (QW > 1) ? $clog2(QW) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [QW-1:0]    dvd_q,   dvd_d;    // dividend bits still to be consumed, MSB first
  logic [WIDTH-1:0] dsr_q,   dsr_d;
  logic [WIDTH-1:0] rem_q,   rem_d;    // partial remainder, always < divisor
  logic [QW-1:0]    quot_q,  quot_d;   // quotient shift register
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic             dbz_q,   dbz_d;

  // Shifted partial remainder needs one extra bit: {r, next bit} can reach
  // 2*divisor-1, which overflows WIDTH bits.
  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   r_diff;
  logic             r_ge;

  // Restoring-division step and handshake-driven state transitions
  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    rem_d   = rem_q;
    quot_d  = quot_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;

    r_shift = {rem_q, dvd_q[QW-1]};
    r_diff  = r_shift - {1'b0, dsr_q};
    r_ge    = (r_shift >= {1'b0, dsr_q});

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          dvd_d = dividend;
          dsr_d = divisor;
          rem_d = '0;
          if (divisor == '0) begin
            // Zero divisor short-circuits straight to a flagged result
            quot_d  = '1;
            dbz_d   = 1'b1;
            cnt_d   = '0;
            state_d = S_DONE;
          end else begin
            quot_d  = '0;
            dbz_d   = 1'b0;
            cnt_d   = CW'(QW - 1);
            state_d = S_BUSY;
          end
        end
      end

      S_BUSY: begin
        dvd_d  = dvd_q << 1;
        quot_d = {quot_q[QW-2:0], r_ge};
        // When r_shift < divisor its top bit is necessarily zero, so the
        // truncation to WIDTH bits is lossless in both branches.
        rem_d  = WIDTH'(r_ge ? r_diff : r_shift);
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      S_DONE: begin
        // Result registers hold until the consumer takes them; quotient and
        // remainder deliberately keep their value after the handshake.
        if (out_ready) begin
          dbz_d   = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      dvd_q   <= '0;
      dsr_q   <= '0;
      rem_q   <= '0;
      quot_q  <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      rem_q   <= rem_d;
      quot_q  <= quot_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign busy        = (state_q == S_BUSY);
  assign out_valid   = (state_q == S_DONE);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

`default_nettype wire

// File: doc/array_divider_seq.md
Name: array_divider_seq

Overview:
- Sequential restoring divider; the inverse of the team's 4x4 combinational array multiplier.
- Accepts a 2*WIDTH-bit dividend (a product-width word) and a WIDTH-bit divisor.
- Returns a 2*WIDTH-bit quotient and a WIDTH-bit remainder after an iterative shift-subtract sequence.
- Sits behind the multiplier datapath, so multiply/divide round-trips can be checked on-chip; valid/ready on both sides.

Parameters:
- WIDTH, 4, divisor and remainder width; dividend and quotient are 2*WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  dividend/divisor pair offered
- in_ready  output  1  block can accept a pair
- dividend  input  2*WIDTH  numerator, unsigned
- divisor  input  WIDTH  denominator, unsigned
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- quotient  output  2*WIDTH  unsigned quotient
- remainder  output  WIDTH  unsigned remainder
- div_by_zero  output  1  result flags divisor == 0
- busy  output  1  high in BUSY state

Behaviour:
- Reset (rst sampled high at a clk edge):
  - State goes to IDLE.
  - in_ready=1; out_valid=0, busy=0, div_by_zero=0.
  - quotient=0, remainder=0; iteration counter=0.
  - Reset overrides everything, including mid-BUSY and mid-DONE; any in-flight result is discarded.
- States: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - Acceptance = in_valid && in_ready at an edge. The block captures dividend and divisor, and clears the partial remainder (WIDTH+1 bits) and the quotient shift register.
  - If divisor==0, go to DONE with quotient=all ones, remainder=0, div_by_zero=1. out_valid rises 1 cycle after acceptance.
  - Otherwise go to BUSY with counter=2*WIDTH-1.
- BUSY, one quotient bit per cycle, MSB first:
  - r' = {r[WIDTH-1:0], next dividend bit}.
  - If r' >= divisor: r = r' - divisor and the quotient bit is 1; else r = r' and the bit is 0.
  - in_ready=0; in_valid is ignored.
  - After the counter-0 iteration, go to DONE.
  - Exactly 2*WIDTH BUSY cycles. out_valid is first high in the cycle after acceptance + 2*WIDTH edges (8 cycles for WIDTH=4).
- DONE:
  - out_valid=1; quotient, remainder and div_by_zero are held stable while out_ready=0 (arbitrary backpressure).
  - On out_valid && out_ready: go to IDLE and clear out_valid and div_by_zero. quotient and remainder keep their last value.
  - No new pair is accepted in the DONE cycle (no bypass). in_ready rises the cycle after the handshake.
- Arithmetic:
  - Unsigned only; remainder < divisor always.
  - quotient*divisor + remainder == dividend for every nonzero divisor.
  - The quotient never overflows because it is 2*WIDTH bits.
  - Internal compare/subtract is WIDTH+1 bits wide, so the r' MSB is not lost.
- Simultaneous events:
  - rst with in_valid: reset wins and nothing is accepted.
  - rst with out_ready in DONE: reset wins.
- Throughput: one division per 2*WIDTH+2 cycles at best.

Test Plan:
- Reset then 200/7 with out_ready=1 -> in_ready drops the cycle after acceptance; out_valid exactly 8 cycles after the acceptance edge; quotient=28 (0x1C), remainder=4, div_by_zero=0.
- Corner values: 225/15 -> q=15 r=0; 255/1 -> q=255 r=0; 0/5 -> q=0 r=0; 14/15 -> q=0 r=14.
- 99/0 -> out_valid 1 cycle after acceptance; q=0xFF, r=0, div_by_zero=1; next division 50/3 -> q=16 r=2, div_by_zero=0.
- 131/9 with out_ready held low 5 cycles in DONE:
  - out_valid stays 1 and q=14, r=5 stay stable throughout.
  - in_valid pulses during BUSY and DONE are not accepted.
  - in_ready returns 1 the cycle after the out handshake.
- rst asserted on the 4th BUSY cycle of 200/7 -> next cycle IDLE, out_valid=0, q=0, r=0, in_ready=1; a following 100/10 returns q=10 r=0.
- Exhaustive all 256x15 nonzero-divisor pairs, back-to-back with random out_ready -> every result satisfies q*d+r==dividend and r<d.
